// File: rtl/sram_burst_ctrl_pkg.sv
// rtl/sram_burst_ctrl_pkg.sv - shared constants and helpers for the SRAM burst controller
package sram_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  localparam int DQ_W_DEF  = 16;
  localparam int WORDS_DEF = 4;
  localparam int WAIT_DEF  = 2;

  // Counter width that stays at least one bit when the range collapses to a single value.
  function automatic int cnt_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// rtl/sram_burst_ctrl_if.sv - host-side request/response bundle for the SRAM burst controller
interface sram_burst_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int DQ_W  = DQ_W_DEF,
  parameter int WORDS = WORDS_DEF
);
  localparam int HW = DQ_W * WORDS;

  logic          wr_en;
  logic          rd_en;
  logic [31:0]   address;
  logic [HW-1:0] wdata;
  logic [HW-1:0] rdata;
  logic          ready;

  modport master (output wr_en, rd_en, address, wdata, input rdata, ready);
  modport slave  (input wr_en, rd_en, address, wdata, output rdata, ready);

endinterface

// File: rtl/sram_burst_ctrl_beat_counter.sv
// rtl/sram_burst_ctrl_beat_counter.sv - nested wait-state / beat counters for one burst
module sram_beat_counter
  import sram_ctrl_pkg::*;
#(
  parameter int WORDS = WORDS_DEF,
  parameter int WAIT  = WAIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       en_i,
  output logic [cnt_bits(WAIT)-1:0]  c_o,
  output logic [cnt_bits(WORDS)-1:0] b_o,
  output logic                       last_wait_o,
  output logic                       last_beat_o
);
  localparam int WAIT_BITS = cnt_bits(WAIT);
  localparam int BEAT_W    = cnt_bits(WORDS);

  logic [WAIT_BITS-1:0] c_q, c_d;
  logic [BEAT_W-1:0]    b_q, b_d;

  assign last_wait_o = (c_q == WAIT_BITS'(WAIT - 1));
  assign last_beat_o = (b_q == BEAT_W'(WORDS - 1));
  assign c_o         = c_q;
  assign b_o         = b_q;

  // The beat counter parks on the last beat so WORDS=1 never leaves beat 0.
  always_comb begin
    c_d = c_q;
    b_d = b_q;
    if (clear_i) begin
      c_d = '0;
      b_d = '0;
    end else if (en_i) begin
      if (last_wait_o) begin
        c_d = '0;
        if (!last_beat_o) b_d = b_q + BEAT_W'(1);
      end else begin
        c_d = c_q + WAIT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
      b_q <= '0;
    end else begin
      c_q <= c_d;
      b_q <= b_d;
    end
  end

endmodule

// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - moves one wide host word as a burst of narrow asynchronous SRAM beats
module sram_burst_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          DQ_W   = DQ_W_DEF,
  parameter int          WORDS  = WORDS_DEF,
  parameter int          WAIT   = WAIT_DEF,
  parameter int          ADDR_W = 18,
  parameter logic [31:0] BASE   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  sram_burst_ctrl_if.slave  host,
  inout  wire  [DQ_W-1:0]   SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);
  localparam int HW        = DQ_W * WORDS;
  localparam int BEAT_BITS = $clog2(WORDS);
  localparam int OFF_BITS  = $clog2(HW / 8);
  localparam int WAIT_BITS = cnt_bits(WAIT);
  localparam int BEAT_W    = cnt_bits(WORDS);

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [HW-1:0]     wdata_q, wdata_d;
  logic [HW-1:0]     rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;

  logic [WAIT_BITS-1:0] c;
  logic [BEAT_W-1:0]    b;
  logic                 last_wait;
  logic                 last_beat;
  logic                 in_access;
  logic                 req;
  logic                 hold_next;
  logic [ADDR_W-1:0]    first_addr;

  assign req        = host.wr_en | host.rd_en;
  assign in_access  = (state_q == ST_ACCESS);
  // Below BASE the subtraction wraps and the result is simply truncated to the pin width.
  assign first_addr = ADDR_W'(((host.address - BASE) >> OFF_BITS) << BEAT_BITS);

  sram_beat_counter #(.WORDS(WORDS), .WAIT(WAIT)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (!in_access),
    .en_i        (in_access),
    .c_o         (c),
    .b_o         (b),
    .last_wait_o (last_wait),
    .last_beat_o (last_beat)
  );

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_ACCESS;
          write_d = host.wr_en;
          wdata_d = host.wdata;
          addr_d  = first_addr;
        end
      end
      ST_ACCESS: begin
        if (last_wait) begin
          if (!write_q) rdata_d[b*DQ_W +: DQ_W] = SRAM_DQ;
          if (last_beat) state_d = ST_DONE;
          else           addr_d  = addr_q + ADDR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered, so they are derived from the state and wait count of the next cycle.
  always_comb begin
    hold_next = in_access && (c == WAIT_BITS'(WAIT - 2));
    ce_n_d    = (state_d != ST_ACCESS);
    oe_n_d    = !((state_d == ST_ACCESS) && !write_d);
    we_n_d    = !((state_d == ST_ACCESS) && write_d && !hold_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_IDLE:   host.ready = !req;
      ST_ACCESS: host.ready = 1'b0;
      ST_DONE:   host.ready = 1'b1;
      default:   host.ready = 1'b0;
    endcase
  end

  assign SRAM_DQ    = (in_access && write_q) ? wdata_q[b*DQ_W +: DQ_W] : {DQ_W{1'bz}};
  assign host.rdata = rdata_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_CE_N  = ce_n_q;
  assign SRAM_OE_N  = oe_n_q;
  assign SRAM_WE_N  = we_n_q;
  assign SRAM_UB_N  = 1'b0;
  assign SRAM_LB_N  = 1'b0;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb/tb_sram_burst_ctrl.sv - scoreboard bench for sram_burst_ctrl with a small SRAM model
module tb_sram_burst_ctrl;
  localparam int DQ_W   = 16;
  localparam int WORDS  = 4;
  localparam int WAIT   = 2;
  localparam int ADDR_W = 18;
  localparam int HW     = DQ_W * WORDS;
  localparam int NCYC   = WORDS * WAIT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tri1 [DQ_W-1:0]   SRAM_DQ;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic ub_n, lb_n, ce_n, oe_n, we_n;

  sram_burst_ctrl_if #(.DQ_W(DQ_W), .WORDS(WORDS)) host_if ();

  sram_burst_ctrl #(.DQ_W(DQ_W), .WORDS(WORDS), .WAIT(WAIT), .ADDR_W(ADDR_W), .BASE(32'd1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host_if),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_WE_N (we_n)
  );

  // SRAM model: words 0..15 and 0x3FFF0..0x3FFFF folded into 32 entries.
  logic [DQ_W-1:0] mem [0:31];
  logic [4:0]      midx;
  assign midx    = {SRAM_ADDR[17], SRAM_ADDR[3:0]};
  assign SRAM_DQ = (!oe_n && we_n) ? mem[midx] : {DQ_W{1'bz}};

  always @(negedge clk) if (!ce_n && !we_n) mem[midx] <= SRAM_DQ;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              oe_n;
    logic              we_n;
    logic              wr;
    logic [DQ_W-1:0]   dq;
  } beat_t;

  typedef struct {
    logic [HW-1:0] rdata;
    int            start;
  } comp_t;

  beat_t beat_q[$];
  comp_t comp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_beats(input logic wr, input logic [HW-1:0] wd,
                            input logic [ADDR_W-1:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      beat_t bt;
      bt.addr = base + ADDR_W'(k / WAIT);
      bt.wr   = wr;
      bt.oe_n = wr;
      bt.we_n = !(wr && ((k % WAIT) != WAIT - 1));
      bt.dq   = wd[(k / WAIT) * DQ_W +: DQ_W];
      beat_q.push_back(bt);
    end
  endtask

  // Monitor: one beat record per active CE cycle, one completion per accepted handshake.
  always @(negedge clk) begin
    if (!ce_n) begin
      if (beat_q.size() == 0) begin
        check("unexpected_beat", 128'(beat_q.size()), 128'd1);
      end else begin
        beat_t bt;
        bt = beat_q.pop_front();
        check("sram_addr", 128'(SRAM_ADDR), 128'(bt.addr));
        check("oe_n", 128'(oe_n), 128'(bt.oe_n));
        check("we_n", 128'(we_n), 128'(bt.we_n));
        if (bt.wr) check("write_dq", 128'(SRAM_DQ), 128'(bt.dq));
      end
    end else begin
      check("idle_oe_n", 128'(oe_n), 128'd1);
      check("idle_we_n", 128'(we_n), 128'd1);
      check("idle_dq_z", 128'(SRAM_DQ), 128'hFFFF);
    end
    if ((host_if.wr_en || host_if.rd_en) && host_if.ready) begin
      if (comp_q.size() == 0) begin
        check("unexpected_ready", 128'(comp_q.size()), 128'd1);
      end else begin
        comp_t cp;
        cp = comp_q.pop_front();
        check("latency", 128'(cyc - cp.start), 128'd9);
        check("rdata", 128'(host_if.rdata), 128'(cp.rdata));
      end
    end
  end

  task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [HW-1:0] wd, input logic [ADDR_W-1:0] base,
                           input logic [HW-1:0] exp_rdata);
    comp_t cp;
    logic  got;
    @(posedge clk); #1;
    host_if.wr_en   = wr;
    host_if.rd_en   = rd;
    host_if.address = addr;
    host_if.wdata   = wd;
    push_beats(wr, wd, base, NCYC);
    cp.rdata = exp_rdata;
    cp.start = cyc;
    comp_q.push_back(cp);
    #1 check("ready_cycle0", 128'(host_if.ready), 128'd0);
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (host_if.ready) got = 1'b1;
    end
    check("ready_timeout", 128'(got), 128'd1);
    @(posedge clk); #1;
    host_if.wr_en = 1'b0;
    host_if.rd_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= '0;
    mem[4]  <= 16'hC0DE; mem[5]  <= 16'hBEEF; mem[6]  <= 16'h0123; mem[7]  <= 16'h4567;
    mem[28] <= 16'hAAA0; mem[29] <= 16'hAAA1; mem[30] <= 16'hAAA2; mem[31] <= 16'hAAA3;
    host_if.wr_en   = 1'b0;
    host_if.rd_en   = 1'b0;
    host_if.address = '0;
    host_if.wdata   = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ce_n", 128'(ce_n), 128'd1);
    check("rst_oe_n", 128'(oe_n), 128'd1);
    check("rst_we_n", 128'(we_n), 128'd1);
    check("rst_dq_z", 128'(SRAM_DQ), 128'hFFFF);
    check("rst_rdata", 128'(host_if.rdata), 128'd0);
    check("rst_ready", 128'(host_if.ready), 128'd1);
    check("rst_addr", 128'(SRAM_ADDR), 128'd0);
    rst = 1'b0;

    do_access(1'b1, 1'b0, 32'd1024, 64'h1122_3344_5566_7788, 18'd0, 64'd0);
    do_access(1'b0, 1'b1, 32'd1024, 64'd0, 18'd0, 64'h1122_3344_5566_7788);
    do_access(1'b0, 1'b1, 32'd1032, 64'd0, 18'd4, 64'h4567_0123_BEEF_C0DE);
    do_access(1'b0, 1'b1, 32'd1016, 64'd0, 18'h3FFFC, 64'hAAA3_AAA2_AAA1_AAA0);
    do_access(1'b1, 1'b1, 32'd1040, 64'hA5A5_A5A5_A5A5_A5A5, 18'd8, 64'hAAA3_AAA2_AAA1_AAA0);

    // Read aborted by reset at the start of its fourth cycle: only three beats reach the pins.
    @(posedge clk); #1;
    host_if.rd_en   = 1'b1;
    host_if.address = 32'd1024;
    push_beats(1'b0, 64'd0, 18'd0, 3);
    repeat (4) @(posedge clk);
    #1;
    rst           = 1'b1;
    host_if.rd_en = 1'b0;
    #1;
    check("abort_ce_n", 128'(ce_n), 128'd1);
    check("abort_oe_n", 128'(oe_n), 128'd1);
    check("abort_we_n", 128'(we_n), 128'd1);
    check("abort_dq_z", 128'(SRAM_DQ), 128'hFFFF);
    check("abort_rdata", 128'(host_if.rdata), 128'd0);
    check("abort_ready", 128'(host_if.ready), 128'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    do_access(1'b0, 1'b1, 32'd1024, 64'd0, 18'd0, 64'h1122_3344_5566_7788);

    repeat (3) @(posedge clk);
    #1;
    check("beats_left", 128'(beat_q.size()), 128'd0);
    check("comps_left", 128'(comp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
